tetris_field: RTL and testbench
===============================

Name: tetris_field

Overview:
Playfield storage for Tetris: holds the 20x10 settled-block color grid and drives it as a packed array straight into the background renderer. Accepts one piece-lock request at a time, writes the four piece cells, then runs a row-scan/shift FSM that removes full lines and reports how many were cleared. Sits between the falling-piece controller (upstream) and the background renderer (downstream).

Parameters:
ROWS, 20, playfield rows; row 0 is the top.
COLS, 10, playfield columns.
CW, 7, color/shape code width; code 0 means an empty cell.

Ports:
Clk  input  1  system clock, the single clock domain.
Reset  input  1  synchronous, active-high reset.
clear_all  input  1  clear the whole field; honoured only in IDLE.
lock_req  input  1  piece-lock request; accepted when lock_req && lock_ready.
lock_ready  output  1  high only in IDLE.
lock_row  input  [3:0][4:0]  row of each of the 4 piece cells.
lock_col  input  [3:0][3:0]  column of each of the 4 piece cells.
lock_color  input  CW  color code written to all 4 cells.
busy  output  1  high in every state except IDLE.
lock_done  output  1  1-cycle pulse when lock processing completes.
lines_cleared  output  3  lines removed by the last lock (0-4); held until the next lock_done.
total_lines  output  16  cumulative cleared lines; saturates at 16'hFFFF.
game_over  output  1  top-out flag (see Optional Feature).
field_color  output  [ROWS-1:0][COLS-1:0][CW-1:0]  registered grid, indexed [row][col].

Behaviour:
- Reset is synchronous and active-high, and overrides every other input, including mid-scan or mid-shift. On reset: grid all 0, state IDLE, lock_ready=1, busy=0, lock_done=0, lines_cleared=0, total_lines=0, game_over=0.
- FSM states:
  - IDLE -> WRITE on acceptance. The 4 coordinates and lock_color are latched on acceptance.
  - WRITE (1 cycle) writes lock_color into each latched cell. A cell with row>=ROWS or col>=COLS is silently dropped. Later cells overwrite earlier ones, with no overlap check. Next state SCAN with the row pointer at ROWS-1.
  - SCAN (1 cycle per visit) tests whether the current row is full, meaning every cell is nonzero.
    - Full row: go to SHIFT.
    - Not full, pointer=0: go to DONE.
    - Otherwise decrement the pointer and stay in SCAN.
  - SHIFT (1 cycle) copies rows 0..r-1 to rows 1..r in one step, zeroes row 0, and increments the per-lock clear counter. Then return to SCAN without changing the pointer, so the shifted-in row is re-tested.
  - DONE (1 cycle) drives lock_done=1, loads lines_cleared, adds the count to total_lines (saturating), then goes to IDLE.
- Latency: if acceptance is at cycle T, lock_done is high at T+22+2k, where k is the number of lines cleared.
- Non-contiguous full rows are all cleared in a single lock.
- clear_all in IDLE zeroes the grid at the next edge and leaves total_lines and game_over unchanged.
- If clear_all and lock_req are both high in IDLE, clear_all wins and the lock is not accepted (lock_ready stays high next cycle).
- lock_req while busy is ignored; the requester must hold it until it sees lock_ready.
- lock_color=0 is legal and writes empties.
- field_color changes only at the WRITE and SHIFT edges and at clear_all/Reset, so the renderer sees a stable grid between edges.

Optional Feature:
Macro: FIELD_TOPOUT_EN.
- Defined: game_over is set in WRITE if any in-range target cell was already nonzero, or if any cell has row>=ROWS (piece locked above the visible field). While set, lock_ready=0 and all requests are refused. It is cleared only by Reset.
- Undefined: game_over is tied to 0 and no lock is ever refused for top-out.

Decomposition:
- Package tetris_pkg holds:
  - ROWS, COLS, CW constants;
  - typedef color_t (logic [CW-1:0]);
  - typedef row_t (color_t [COLS-1:0]);
  - typedef field_t (row_t [ROWS-1:0]);
  - FSM enum field_state_t {IDLE, WRITE, SCAN, SHIFT, DONE}.
- Sub-module field_row_full: combinational, input row_t, output 1 = all cells nonzero. One instance, fed by the row mux at the scan pointer.

Test Plan:
1. Empty field; lock cells (19,0),(19,1),(19,2),(19,3), color 7'h01 -> lock_done at T+22; lines_cleared=0; those 4 cells read 7'h01.
2. Row 19 cols 0-5 prefilled with 7'h02 and row 18 col 0 with 7'h03; lock (19,6..9), color 7'h04 -> lock_done at T+24; lines_cleared=1; row 19 col 0 = 7'h03; total_lines=1.
3. Rows 16-19 full except col 9; vertical I at col 9 rows 16-19 -> lines_cleared=4; whole grid 0; lock_done at T+30; total_lines increments by 4.
4. Rows 19 and 17 completed by one lock, row 18 not full -> lines_cleared=2; old row 18 now at row 19; lock_done at T+26.
5. Reset asserted during SHIFT -> next cycle grid all 0, lock_ready=1, total_lines=0, no lock_done pulse.
6. With FIELD_TOPOUT_EN defined, lock a cell onto occupied (5,4) -> game_over=1; later lock_req is never accepted. Without the macro -> game_over stays 0 and the cell is overwritten.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield types and constants for the Tetris field storage block.
package tetris_pkg;

    localparam int ROWS = 20;   // playfield rows, row 0 is the top
    localparam int COLS = 10;   // playfield columns
    localparam int CW   = 7;    // color/shape code width, 0 = empty cell

    typedef logic [CW-1:0]   color_t;
    typedef color_t [COLS-1:0] row_t;
    typedef row_t [ROWS-1:0]   field_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCAN,
        SHIFT,
        DONE
    } field_state_t;

    // True when a piece cell coordinate lands inside the visible grid.
    function automatic logic in_field(input logic [4:0] row, input logic [3:0] col);
        return (row < 5'(ROWS)) && (col < 4'(COLS));
    endfunction

endpackage

// File: rtl/field_row_full.sv
// Combinational full-line detector: high when every cell of the row is occupied.
module field_row_full
    import tetris_pkg::*;
(
    input  row_t i_row,
    output logic o_full
);

    // A single empty cell makes the row not full.
    always_comb begin
        o_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (i_row[c] == '0) begin
                o_full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tetris_field.sv
// Tetris playfield storage: settled-block grid, piece lock, line clear.
// Optional build macro FIELD_TOPOUT_EN enables the top-out (game_over) flag;
// without it game_over is tied low and locks are never refused.
module tetris_field
    import tetris_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            clear_all,
    input  logic            lock_req,
    output logic            lock_ready,
    input  logic [3:0][4:0] lock_row,
    input  logic [3:0][3:0] lock_col,
    input  color_t          lock_color,
    output logic            busy,
    output logic            lock_done,
    output logic [2:0]      lines_cleared,
    output logic [15:0]     total_lines,
    output logic            game_over,
    output field_t          field_color
);

    field_state_t    r_state;
    field_t          r_field;
    logic [3:0][4:0] r_row;
    logic [3:0][3:0] r_col;
    color_t          r_color;
    logic [4:0]      r_ptr;
    logic [2:0]      r_cnt;
    logic            r_lock_done;
    logic [2:0]      r_lines;
    logic [15:0]     r_total;

    row_t            w_scan_row;
    logic            w_full;
    logic            w_accept;

    // Cumulative line counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

`ifdef FIELD_TOPOUT_EN
    logic r_go;
    logic w_hit;

    // A lock landing on settled blocks or above the visible field tops out.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_row[i] >= 5'(ROWS)) begin
                w_hit = 1'b1;
            end else if (r_col[i] < 4'(COLS) && r_field[r_row[i]][r_col[i]] != '0) begin
                w_hit = 1'b1;
            end
        end
    end

    // Sticky top-out flag, cleared only by Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_go <= 1'b0;
        end else if (r_state == WRITE && w_hit) begin
            r_go <= 1'b1;
        end
    end

    assign game_over = r_go;
`else
    assign game_over = 1'b0;
`endif

    // clear_all has priority over a lock request in IDLE.
    assign w_accept = (r_state == IDLE) && lock_req && !clear_all && !game_over;

    // Only the row under the scan pointer is tested for completeness.
    assign w_scan_row = r_field[r_ptr];

    field_row_full u_row_full (
        .i_row  (w_scan_row),
        .o_full (w_full)
    );

    // Capture the piece coordinates and color when a lock is accepted.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_row   <= lock_row;
            r_col   <= lock_col;
            r_color <= lock_color;
        end
    end

    // Lock sequencing: write, scan bottom-up, shift out full rows, report.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_lock_done <= 1'b0;
            r_lines     <= '0;
            r_total     <= '0;
        end else begin
            r_lock_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_state <= SCAN;
                    r_ptr   <= 5'(ROWS - 1);
                    r_cnt   <= '0;
                end
                SCAN: begin
                    if (w_full) begin
                        r_state <= SHIFT;
                    end else if (r_ptr == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_ptr <= r_ptr - 5'd1;
                    end
                end
                SHIFT: begin
                    // Pointer stays put so the row shifted in is re-tested.
                    r_cnt   <= r_cnt + 3'd1;
                    r_state <= SCAN;
                end
                DONE: begin
                    r_lock_done <= 1'b1;
                    r_lines     <= r_cnt;
                    r_total     <= sat_add16(r_total, r_cnt);
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Grid updates happen only on clear, piece write and row shift edges.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_field <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_all) begin
                        r_field <= '0;
                    end
                end
                WRITE: begin
                    // Later cells win on overlap; off-grid cells are dropped.
                    for (int i = 0; i < 4; i++) begin
                        if (in_field(r_row[i], r_col[i])) begin
                            r_field[r_row[i]][r_col[i]] <= r_color;
                        end
                    end
                end
                SHIFT: begin
                    for (int r = 1; r < ROWS; r++) begin
                        if (5'(r) <= r_ptr) begin
                            r_field[r] <= r_field[r-1];
                        end
                    end
                    r_field[0] <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign lock_ready    = (r_state == IDLE) && !game_over;
    assign busy          = (r_state != IDLE);
    assign lock_done     = r_lock_done;
    assign lines_cleared = r_lines;
    assign total_lines   = r_total;
    assign field_color   = r_field;

endmodule

// File: tb/tb_tetris_field.sv
// Self-checking bench for tetris_field: directed steps plus random locks,
// compared against a behavioural playfield model (FIELD_TOPOUT_EN aware).
module tb_tetris_field;
    import tetris_pkg::*;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            clear_all = 1'b0;
    logic            lock_req = 1'b0;
    logic            lock_ready;
    logic [3:0][4:0] lock_row = '0;
    logic [3:0][3:0] lock_col = '0;
    logic [6:0]      lock_color = '0;
    logic            busy;
    logic            lock_done;
    logic [2:0]      lines_cleared;
    logic [15:0]     total_lines;
    logic            game_over;
    field_t          field_color;

    tetris_field dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .clear_all     (clear_all),
        .lock_req      (lock_req),
        .lock_ready    (lock_ready),
        .lock_row      (lock_row),
        .lock_col      (lock_col),
        .lock_color    (lock_color),
        .busy          (busy),
        .lock_done     (lock_done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines),
        .game_over     (game_over),
        .field_color   (field_color)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int m[20][10];
    int m_total;
    int m_lines;
    bit m_go;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grid(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                if (field_color[r][c] !== 7'(m[r][c])) bad++;
        check({tag, "/grid_bad_cells"}, bad, 0);
    endtask

    // Remove every full row, letting remaining rows fall to the bottom.
    function automatic int model_clear();
        int t[20][10];
        int dst, k;
        bit full;
        dst = 19;
        k = 0;
        for (int src = 19; src >= 0; src--) begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (m[src][c] == 0) full = 1'b0;
            if (full) k++;
            else begin
                for (int c = 0; c < 10; c++) t[dst][c] = m[src][c];
                dst--;
            end
        end
        for (int r = 0; r <= dst; r++)
            for (int c = 0; c < 10; c++) t[r][c] = 0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) m[r][c] = t[r][c];
        return k;
    endfunction

    task automatic model_zero();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) m[r][c] = 0;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        clear_all = 1'b0;
        lock_req = 1'b0;
        tick();
        Reset = 1'b0;
        model_zero();
        m_total = 0;
        m_lines = 0;
        m_go = 1'b0;
        check({tag, "/lock_ready"}, lock_ready, 1);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/lock_done"}, lock_done, 0);
        check({tag, "/lines"}, lines_cleared, 0);
        check({tag, "/total"}, total_lines, 0);
        check({tag, "/game_over"}, game_over, 0);
        check_grid(tag);
    endtask

    task automatic do_clear(input string tag);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        model_zero();
        check_grid(tag);
        check({tag, "/total"}, total_lines, m_total);
        check({tag, "/game_over"}, game_over, 32'(m_go));
        check({tag, "/busy"}, busy, 0);
    endtask

    task automatic do_lock(input logic [3:0][4:0] rows, input logic [3:0][3:0] cols,
                           input logic [6:0] color, input string tag);
        int k, n;
        bit seen;
`ifdef FIELD_TOPOUT_EN
        bit hit;
`endif
        check({tag, "/ready"}, lock_ready, 32'(!m_go));
        lock_row = rows;
        lock_col = cols;
        lock_color = color;
        if (m_go) begin
            lock_req = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (busy !== 1'b0 || lock_done !== 1'b0) seen = 1'b1;
            end
            lock_req = 1'b0;
            check({tag, "/refused"}, seen, 0);
            check_grid(tag);
            return;
        end
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        check({tag, "/busy"}, busy, 1);
`ifdef FIELD_TOPOUT_EN
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rows[i] >= 20) hit = 1'b1;
            else if (cols[i] < 10 && m[rows[i]][cols[i]] != 0) hit = 1'b1;
        end
        if (hit) m_go = 1'b1;
`endif
        for (int i = 0; i < 4; i++)
            if (rows[i] < 20 && cols[i] < 10) m[rows[i]][cols[i]] = int'(color);
        k = model_clear();
        m_lines = k;
        m_total = (m_total + k > 65535) ? 65535 : m_total + k;
        n = 0;
        while (lock_done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        check({tag, "/latency"}, n, 22 + 2 * k);
        check({tag, "/lines"}, lines_cleared, m_lines);
        check({tag, "/total"}, total_lines, m_total);
        check({tag, "/game_over"}, game_over, 32'(m_go));
        check({tag, "/ready_after"}, lock_ready, 32'(!m_go));
        check_grid(tag);
        tick();
        check({tag, "/done_pulse"}, lock_done, 0);
    endtask

    // Lock the masked columns of one row, four cells at a time.
    task automatic fill_mask(input logic [4:0] row, input logic [9:0] mask, input logic [6:0] color);
        logic [3:0][3:0] cs;
        int n;
        n = 0;
        cs = '0;
        for (int c = 0; c < 10; c++) begin
            if (mask[c]) begin
                cs[n] = 4'(c);
                n++;
                if (n == 4) begin
                    do_lock({4{row}}, cs, color, "fill");
                    n = 0;
                end
            end
        end
        if (n > 0) begin
            for (int i = n; i < 4; i++) cs[i] = cs[n-1];
            do_lock({4{row}}, cs, color, "fill");
        end
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0][4:0] rs;
        logic [3:0][3:0] cs;
        bit seen;

        do_reset("reset");

        // Four cells on the bottom row, no clear
        do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd3, 4'd2, 4'd1, 4'd0}, 7'h01, "t1");
        check("t1/cell190", field_color[19][0], 7'h01);
        check("t1/cell193", field_color[19][3], 7'h01);
        check("t1/lines", lines_cleared, 0);

        // Single line clear, row above drops
        do_clear("t2clr");
        fill_mask(5'd19, 10'b00_0011_1111, 7'h02);
        fill_mask(5'd18, 10'b00_0000_0001, 7'h03);
        do_lock({5'd19, 5'd19, 5'd19, 5'd19}, {4'd9, 4'd8, 4'd7, 4'd6}, 7'h04, "t2");
        check("t2/lines", lines_cleared, 1);
        check("t2/cell190", field_color[19][0], 7'h03);
        check("t2/total", total_lines, 1);

        // Tetris: four lines at once
        do_clear("t3clr");
        for (int r = 16; r < 20; r++) fill_mask(5'(r), 10'h1FF, 7'(r - 10));
        do_lock({5'd19, 5'd18, 5'd17, 5'd16}, {4'd9, 4'd9, 4'd9, 4'd9}, 7'h06, "t3");
        check("t3/lines", lines_cleared, 4);
        check("t3/total", total_lines, 5);

        // Non-contiguous rows 17 and 19
        do_clear("t4clr");
        fill_mask(5'd19, 10'h1FF, 7'h08);
        fill_mask(5'd17, 10'h1FF, 7'h09);
        fill_mask(5'd18, 10'h001, 7'h0A);
        do_lock({5'd17, 5'd19, 5'd17, 5'd19}, {4'd9, 4'd9, 4'd9, 4'd9}, 7'h0B, "t4");
        check("t4/lines", lines_cleared, 2);
        check("t4/cell190", field_color[19][0], 7'h0A);
        check("t4/cell189", field_color[18][9], 7'h00);

        // clear_all beats a simultaneous lock request
        clear_all = 1'b1;
        lock_req = 1'b1;
        lock_row = {4{5'd10}};
        lock_col = '0;
        lock_color = 7'h11;
        tick();
        clear_all = 1'b0;
        lock_req = 1'b0;
        model_zero();
        check("prio/busy", busy, 0);
        check("prio/ready", lock_ready, 32'(!m_go));
        check_grid("prio");

        // Random locks, including off-grid cells and empty color
        for (int it = 0; it < 40; it++) begin
            if (it % 10 == 9) do_clear("rclr");
            if (it % 3 == 0) begin
                fill_mask(5'd19, 10'h3FF & ~(10'd1 << $urandom_range(9)), 7'($urandom_range(127, 1)));
            end
            for (int i = 0; i < 4; i++) begin
                rs[i] = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 20)) : 5'($urandom_range(19, 12));
                cs[i] = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
            end
            do_lock(rs, cs, 7'($urandom_range(127)), "rand");
        end

        // Reset while a row is being shifted
        do_reset("t5pre");
        fill_mask(5'd19, 10'h1FF, 7'h0C);
        lock_row = {4{5'd19}};
        lock_col = {4{4'd9}};
        lock_color = 7'h0D;
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        tick();
        tick();
        check("t5/busy_mid", busy, 1);
        check("t5/total_mid", total_lines, 0);
        do_reset("t5");
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (lock_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("t5/quiet", seen, 0);

        // Lock onto an occupied cell
        do_lock({4{5'd5}}, {4{4'd4}}, 7'h09, "t6a");
        do_lock({4{5'd5}}, {4{4'd4}}, 7'h0E, "t6b");
`ifdef FIELD_TOPOUT_EN
        check("t6/game_over", game_over, 1);
        check("t6/cell54", field_color[5][4], 7'h0E);
        do_lock({4{5'd19}}, {4{4'd0}}, 7'h01, "t6c");
        check("t6/ready", lock_ready, 0);
`else
        check("t6/game_over", game_over, 0);
        check("t6/cell54", field_color[5][4], 7'h0E);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
